matmul_engine: RTL and testbench

Parametrised signed N×N matrix multiplier that computes C = A·B. Software loads A and B element-by-element through a write port, pulses `start`, and reads C back through a registered read port. The block has configurable order, element width and parallel MAC lanes, a full-precision accumulator, and a selectable wrap or saturate output mode with a sticky overflow flag. It sits behind the peripheral register/memory bridge as the compute core of the matrix accelerator.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/matmul_mac_lane.sv | 37 +++
 rtl/matmul_engine.sv | 178 +++++++++++++++++
 tb/tb_matmul_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix multiply engine: FSM states,
// index-width helper and the wrap/saturate writeback decision.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SAT_PASS = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  localparam int unsigned MIN_IDX_W = 1;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? MIN_IDX_W : $clog2(n);
  endfunction

  // Chooses between passing the wrapped low bits and clamping to a rail.
  function automatic sat_e sat_action(input logic sat_en, input logic fits, input logic neg);
    if (!sat_en || fits) return SAT_PASS;
    return neg ? SAT_LO : SAT_HI;
  endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One signed multiply-accumulate lane; acc_o is the running sum including the
// current product so the writeback can use it on the same edge.
module matmul_mac_lane #(
  parameter int W    = 32,
  parameter int ACCW = 66
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [W-1:0]    a_i,
  input  logic signed [W-1:0]    b_i,
  output logic signed [ACCW-1:0] acc_o
);

  logic signed [ACCW-1:0]  acc_q;
  logic signed [2*W-1:0]   a_ext;
  logic signed [2*W-1:0]   b_ext;
  logic signed [2*W-1:0]   prod;

  assign a_ext = {{W{a_i[W-1]}}, a_i};
  assign b_ext = {{W{b_i[W-1]}}, b_i};
  assign prod  = a_ext * b_ext;
  assign acc_o = acc_q + {{(ACCW-2*W){prod[2*W-1]}}, prod};

  // Clear wins over accumulate so a finished dot product restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_o;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Signed NxN matrix multiplier C = A*B with LANES parallel MAC lanes,
// element-wise load/read ports and wrap or saturate writeback.
module matmul_engine #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int LANES = 1,
  parameter int ACCW  = 2*W + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic                    wr_sel_i,
  input  logic [$clog2(N*N)-1:0]  wr_addr_i,
  input  logic [W-1:0]            wr_data_i,
  input  logic                    start_i,
  input  logic                    sat_mode_i,
  input  logic [$clog2(N*N)-1:0]  rd_addr_i,
  output logic [W-1:0]            rd_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o
);
  import matmul_pkg::*;

  localparam int AW     = $clog2(N*N);
  localparam int IW     = idx_w(N);
  localparam int GROUPS = N / LANES;
  localparam int GW     = idx_w(GROUPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS-1);
  localparam logic [AW:0]   NN       = (AW+1)'(N*N);

  logic [W-1:0] a_mem [N*N];
  logic [W-1:0] b_mem [N*N];
  logic [W-1:0] c_mem [N*N];

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [GW-1:0] g_q, g_d;
  logic [IW-1:0] k_q, k_d;
  logic          ovf_q, ovf_d;
  logic          sat_q, sat_d;
  logic [W-1:0]  rd_data_q;

  logic running, accept_start, last_k, wr_ok, rd_ok;
  logic [AW-1:0] a_idx;
  logic [AW-1:0] b_idx [LANES];
  logic [AW-1:0] c_idx [LANES];
  logic signed [ACCW-1:0] lane_acc [LANES];
  logic [W-1:0]     wb_data [LANES];
  logic [LANES-1:0] lane_fits;
  logic [LANES-1:0] wb_ovf;

  assign running      = (state_q == RUN);
  assign accept_start = start_i && !running;
  assign last_k       = (k_q == LAST_IDX);
  assign wr_ok        = wr_en_i && !running && ({1'b0, wr_addr_i} < NN);
  assign rd_ok        = ({1'b0, rd_addr_i} < NN);
  assign a_idx        = AW'(int'(i_q) * N + int'(k_q));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign b_idx[l] = AW'(int'(k_q) * N + int'(g_q) * LANES + l);
    assign c_idx[l] = AW'(int'(i_q) * N + int'(g_q) * LANES + l);

    matmul_mac_lane #(.W(W), .ACCW(ACCW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr_i (accept_start || (running && last_k)),
      .en_i  (running),
      .a_i   (a_mem[a_idx]),
      .b_i   (b_mem[b_idx[l]]),
      .acc_o (lane_acc[l])
    );

    // The sum fits in W signed bits when every bit from W-1 upward matches the sign.
    assign lane_fits[l] = (&lane_acc[l][ACCW-1:W-1]) || !(|lane_acc[l][ACCW-1:W-1]);
    assign wb_ovf[l]    = ~lane_fits[l];

    always_comb begin
      wb_data[l] = lane_acc[l][W-1:0];
      case (sat_action(sat_q, lane_fits[l], lane_acc[l][ACCW-1]))
        SAT_HI:  wb_data[l] = {1'b0, {(W-1){1'b1}}};
        SAT_LO:  wb_data[l] = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
    end
  end

  // Walk row i, column group g, inner index k; the last k of the last cell ends the run.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    g_d     = g_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          i_d     = '0;
          g_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          sat_d   = sat_mode_i;
        end
      end
      RUN: begin
        if (last_k) begin
          ovf_d = ovf_q | (|wb_ovf);
          k_d   = '0;
          if (g_q == LAST_GRP) begin
            g_d = '0;
            if (i_q == LAST_IDX) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            g_d = g_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      g_q     <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      g_q     <= g_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
    end
  end

  // Matrix storage carries no reset; contents are reloaded by software after reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel_i) begin
        b_mem[wr_addr_i] <= wr_data_i;
      end else begin
        a_mem[wr_addr_i] <= wr_data_i;
      end
    end
    if (running && last_k) begin
      for (int l = 0; l < LANES; l++) begin
        c_mem[c_idx[l]] <= wb_data[l];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_ok ? c_mem[rd_addr_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;
  assign busy_o    = running;
  assign done_o    = (state_q == DONE);
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench driving a LANES=1 and a LANES=2 engine with identical
// directed stimulus; read results are queued and checked by a monitor.
module tb_matmul_engine;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NN = N * N;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrEn, wrSel, startReq, satMode, rdReq;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [W-1:0]  wrData;
  logic [W-1:0]  rdData1, rdData2;
  logic          busy1, busy2, done1, done2, ovf1, ovf2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] matA [NN];
  logic [W-1:0] matB [NN];
  logic [W-1:0] matC [NN];

  typedef struct {
    int           addr;
    logic [W-1:0] exp;
  } rdExp_t;
  rdExp_t expQ[$];

  always #5 clk = ~clk;

  matmul_engine #(.N(N), .W(W), .LANES(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en_i(wrEn), .wr_sel_i(wrSel), .wr_addr_i(wrAddr),
    .wr_data_i(wrData), .start_i(startReq), .sat_mode_i(satMode), .rd_addr_i(rdAddr),
    .rd_data_o(rdData1), .busy_o(busy1), .done_o(done1), .ovf_o(ovf1)
  );

  matmul_engine #(.N(N), .W(W), .LANES(2)) dut2 (
    .clk(clk), .reset(reset), .wr_en_i(wrEn), .wr_sel_i(wrSel), .wr_addr_i(wrAddr),
    .wr_data_i(wrData), .start_i(startReq), .sat_mode_i(satMode), .rd_addr_i(rdAddr),
    .rd_data_o(rdData2), .busy_o(busy2), .done_o(done2), .ovf_o(ovf2)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeElem(input logic sel, input int addr, input logic [W-1:0] data);
    wrEn   = 1'b1;
    wrSel  = sel;
    wrAddr = AW'(addr);
    wrData = data;
    tick();
    wrEn   = 1'b0;
  endtask

  // Optionally raises start together with the final B write.
  task automatic applyStimulus(input bit startWithLast);
    for (int a = 0; a < NN; a++) writeElem(1'b0, a, matA[a]);
    for (int a = 0; a < NN; a++) begin
      if (startWithLast && a == NN-1) startReq = 1'b1;
      writeElem(1'b1, a, matB[a]);
      startReq = 1'b0;
    end
  endtask

  task automatic runAndWait(input bit preStarted, input bit inject, input string tag);
    int c1 = 0;
    int c2 = 0;
    if (!preStarted) begin
      startReq = 1'b1;
      tick();
      startReq = 1'b0;
    end
    checkOutput($sformatf("%s busyAfterStart L1", tag), busy1, 1);
    checkOutput($sformatf("%s busyAfterStart L2", tag), busy2, 1);
    checkOutput($sformatf("%s doneClearedOnStart L1", tag), done1, 0);
    for (int cyc = 1; cyc <= 200 && (c1 == 0 || c2 == 0); cyc++) begin
      if (inject && cyc == 10) begin
        startReq = 1'b1;
        wrEn     = 1'b1;
        wrSel    = 1'b0;
        wrAddr   = '0;
        wrData   = 32'd99;
      end
      tick();
      startReq = 1'b0;
      wrEn     = 1'b0;
      if (c1 == 0 && done1) c1 = cyc;
      if (c2 == 0 && done2) c2 = cyc;
    end
    checkOutput($sformatf("%s doneCycle L1", tag), 64'(c1), 64);
    checkOutput($sformatf("%s doneCycle L2", tag), 64'(c2), 32);
    checkOutput($sformatf("%s busyAfterDone L1", tag), busy1, 0);
    checkOutput($sformatf("%s busyAfterDone L2", tag), busy2, 0);
  endtask

  task automatic readAll();
    for (int a = 0; a < NN; a++) begin
      rdAddr = AW'(a);
      rdReq  = 1'b1;
      expQ.push_back('{a, matC[a]});
      tick();
    end
    rdReq = 1'b0;
    tick();
    tick();
  endtask

  task automatic checkOvf(input string tag, input logic expected);
    checkOutput($sformatf("%s ovf L1", tag), ovf1, expected);
    checkOutput($sformatf("%s ovf L2", tag), ovf2, expected);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput($sformatf("%s busy L1", tag), busy1, 0);
    checkOutput($sformatf("%s busy L2", tag), busy2, 0);
    checkOutput($sformatf("%s done L1", tag), done1, 0);
    checkOutput($sformatf("%s done L2", tag), done2, 0);
    checkOutput($sformatf("%s ovf L1", tag), ovf1, 0);
    checkOutput($sformatf("%s ovf L2", tag), ovf2, 0);
    checkOutput($sformatf("%s rdData L1", tag), rdData1, 0);
    checkOutput($sformatf("%s rdData L2", tag), rdData2, 0);
  endtask

  task automatic setIdentity();
    for (int a = 0; a < NN; a++) begin
      matA[a] = (a / N == a % N) ? 32'd1 : 32'd0;
      matB[a] = W'(a);
      matC[a] = W'(a);
    end
  endtask

  task automatic setUniform(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv);
    for (int a = 0; a < NN; a++) begin
      matA[a] = av;
      matB[a] = bv;
      matC[a] = cv;
    end
  endtask

  // Monitor: a read issued before an edge presents rd_data after that edge.
  initial begin
    logic   pend;
    rdExp_t e;
    forever begin
      @(posedge clk);
      pend = rdReq;
      @(negedge clk);
      if (pend) begin
        if (expQ.size() == 0) begin
          checkOutput("rdQueueUnderflow", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("rdC[%0d] L1", e.addr), rdData1, e.exp);
          checkOutput($sformatf("rdC[%0d] L2", e.addr), rdData2, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    wrEn     = 1'b0;
    wrSel    = 1'b0;
    wrAddr   = '0;
    wrData   = '0;
    startReq = 1'b0;
    satMode  = 1'b0;
    rdAddr   = '0;
    rdReq    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;
    tick();

    $display("[TB] identity with ignored mid-run start/write");
    setIdentity();
    applyStimulus(1'b0);
    runAndWait(1'b0, 1'b1, "ident");
    checkOvf("ident", 1'b0);
    readAll();

    $display("[TB] negative values, start together with last write");
    setUniform(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFF4);
    applyStimulus(1'b1);
    runAndWait(1'b1, 1'b0, "neg");
    checkOvf("neg", 1'b0);
    readAll();

    $display("[TB] overflow, wrap mode");
    setUniform(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFF8);
    applyStimulus(1'b0);
    runAndWait(1'b0, 1'b0, "wrap");
    checkOvf("wrap", 1'b1);
    readAll();

    $display("[TB] overflow, saturate mode latched at start");
    setUniform(32'h7FFF_FFFF, 32'd2, 32'h7FFF_FFFF);
    satMode  = 1'b1;
    startReq = 1'b1;
    tick();
    startReq = 1'b0;
    satMode  = 1'b0;
    runAndWait(1'b1, 1'b0, "sat");
    checkOvf("sat", 1'b1);
    readAll();

    $display("[TB] reset in the middle of a run");
    startReq = 1'b1;
    tick();
    startReq = 1'b0;
    repeat (20) tick();
    checkOutput("preReset busy L1", busy1, 1);
    checkOutput("preReset ovf L1", ovf1, 1);
    checkOutput("preReset rdData L1", rdData1, 32'h7FFF_FFFF);
    reset = 1'b1;
    #1;
    checkResetState("midRunReset");
    #3;
    reset = 1'b0;
    tick();
    setIdentity();
    applyStimulus(1'b0);
    runAndWait(1'b0, 1'b0, "postReset");
    checkOvf("postReset", 1'b0);
    readAll();

    repeat (3) tick();
    checkOutput("scoreboardDrained", 64'(expQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
